// File: rtl/pos_fp_subtractor.sv
// Positive half-precision subtractor c = |a| - |b|, multi-cycle FSM, truncating, no denormals.
// Latency 3..13 cycles start-to-done; start is ignored while busy (no backpressure path).
module pos_fp_subtractor (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] c,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    SUB   = 3'd2,
    NORM  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state, nstate;

  logic [14:0] opa, opb;
  logic        sign;
  logic [4:0]  exp;
  logic [10:0] mant_l, mant_s, m;
  logic [15:0] c_hold;
  logic [15:0] result;

  // Sign bits are deliberately discarded; operands are magnitudes only.
  logic unused_signs;
  assign unused_signs = a[15] ^ b[15];

  function automatic logic [10:0] mant_of(input logic [14:0] op);
    mant_of = (op[14:10] == 5'd0) ? 11'd0 : {1'b1, op[9:0]};
  endfunction

  logic        b_gt_a;
  logic [14:0] opl, ops;
  logic [4:0]  shamt;
  logic [10:0] s_aligned;
  logic [10:0] diff;

  always_comb begin
    b_gt_a    = (opb > opa);
    opl       = b_gt_a ? opb : opa;
    ops       = b_gt_a ? opa : opb;
    shamt     = opl[14:10] - ops[14:10];
    s_aligned = (shamt >= 5'd11) ? 11'd0 : (mant_of(ops) >> shamt);
    diff      = mant_l - mant_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:  if (start) nstate = ALIGN;
      ALIGN: nstate = SUB;
      SUB:   nstate = ((diff == 11'd0) || diff[10]) ? DONE : NORM;
      NORM: begin
        if (m[10])             nstate = DONE;
        else if (exp > 5'd1)   nstate = m[9] ? DONE : NORM;
        else                   nstate = DONE;
      end
      DONE:  nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    result = {sign, exp, m[9:0]};
    busy   = (state != IDLE);
    done   = (state == DONE);
    c      = done ? result : c_hold;
  end

  // Zero results and underflow clear sign/exp/m so DONE emits 16'h0000.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa    <= 15'd0;
      opb    <= 15'd0;
      sign   <= 1'b0;
      exp    <= 5'd0;
      mant_l <= 11'd0;
      mant_s <= 11'd0;
      m      <= 11'd0;
      c_hold <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opa <= a[14:0];
            opb <= b[14:0];
          end
        end
        ALIGN: begin
          sign   <= b_gt_a;
          exp    <= opl[14:10];
          mant_l <= mant_of(opl);
          mant_s <= s_aligned;
        end
        SUB: begin
          if (diff == 11'd0) begin
            sign <= 1'b0;
            exp  <= 5'd0;
            m    <= 11'd0;
          end else begin
            m <= diff;
          end
        end
        NORM: begin
          if (!m[10]) begin
            if (exp > 5'd1) begin
              m   <= {m[9:0], 1'b0};
              exp <= exp - 5'd1;
            end else begin
              sign <= 1'b0;
              exp  <= 5'd0;
              m    <= 11'd0;
            end
          end
        end
        DONE:    c_hold <= result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pos_fp_subtractor.sv
// Directed bench for pos_fp_subtractor: vector table plus busy-start and mid-NORM reset sequences.
module tb_pos_fp_subtractor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a, b;
  logic [15:0] c;
  logic        busy, done;

  always #5 clk = ~clk;

  pos_fp_subtractor dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .c     (c),
    .busy  (busy),
    .done  (done)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int dbl   = 0;
  logic done_q = 1'b0;

  always @(negedge clk) begin
    if (done && done_q) dbl++;
    done_q = done;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  // Called with start already driven; returns one cycle after the expected DONE.
  task automatic collect(input string tag, input logic [15:0] exp_c, input int exp_lat);
    logic        got;
    logic        busy_ok;
    logic [15:0] res;
    int          lat;
    got = 1'b0; busy_ok = 1'b1; res = 16'h0000; lat = 0;
    @(posedge clk); #1;
    start = 1'b0;
    while (!got && lat < 30) begin
      lat++;
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        got = 1'b1;
        res = c;
      end else begin
        @(posedge clk); #1;
      end
    end
    check({tag, "_done_seen"}, {31'd0, got}, 32'd1);
    check({tag, "_c"}, {16'd0, res}, {16'd0, exp_c});
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_high"}, {31'd0, busy_ok}, 32'd1);
    @(posedge clk); #1;
    check({tag, "_done_1cyc"}, {31'd0, done}, 32'd0);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    check({tag, "_c_hold"}, {16'd0, c}, {16'd0, exp_c});
  endtask

  task automatic run(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                     input logic [15:0] exp_c, input int exp_lat);
    @(negedge clk);
    a = ta; b = tb_v; start = 1'b1;
    collect(tag, exp_c, exp_lat);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    int          lat;
  } vec_t;

  vec_t vecs [14];

  initial begin
    vecs[0]  = '{16'h4200, 16'h3C00, 16'h4000, 3};   // 3 - 1
    vecs[1]  = '{16'h3C00, 16'h4200, 16'hC000, 3};   // 1 - 3
    vecs[2]  = '{16'h3C00, 16'h3C00, 16'h0000, 3};   // equal -> +0
    vecs[3]  = '{16'h3C00, 16'h3800, 16'h3800, 4};   // 1 - 0.5
    vecs[4]  = '{16'h6400, 16'h3C00, 16'h63FE, 4};   // 1024 - 1, truncation
    vecs[5]  = '{16'h0000, 16'h3C00, 16'hBC00, 3};   // a zero
    vecs[6]  = '{16'h4500, 16'h0000, 16'h4500, 3};   // b zero
    vecs[7]  = '{16'h0000, 16'h0000, 16'h0000, 3};   // both zero
    vecs[8]  = '{16'h3C01, 16'h3C00, 16'h1400, 13};  // 10 NORM steps
    vecs[9]  = '{16'h0401, 16'h0400, 16'h0000, 4};   // immediate underflow
    vecs[10] = '{16'h0C01, 16'h0C00, 16'h0000, 6};   // underflow after 2 shifts
    vecs[11] = '{16'h7800, 16'h3C00, 16'h7800, 3};   // shift >= 11
    vecs[12] = '{16'h3800, 16'h3C00, 16'hB800, 4};   // negative with NORM
    vecs[13] = '{16'hC200, 16'hBC00, 16'h4000, 3};   // sign bits ignored

    rst = 1'b1; start = 1'b0; a = 16'h0000; b = 16'h0000;
    #1;
    check("reset_c", {16'd0, c}, 32'h0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 14; i++)
      run($sformatf("v%0d", i), vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].lat);

    // start held high while busy, with different operands, must be ignored
    @(negedge clk);
    a = 16'h4200; b = 16'h3C00; start = 1'b1;
    @(posedge clk); #1;
    a = 16'h3C00; b = 16'h4200;
    check("busy_start_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_start_done", {31'd0, done}, 32'd1);
    check("busy_start_c", {16'd0, c}, 32'h4000);
    @(posedge clk); #1;
    check("busy_start_idle", {31'd0, busy}, 32'd0);
    check("busy_start_hold", {16'd0, c}, 32'h4000);

    // reset during NORM aborts immediately
    @(negedge clk);
    a = 16'h3C01; b = 16'h3C00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("norm_rst_pre_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("norm_rst_busy", {31'd0, busy}, 32'd0);
    check("norm_rst_c", {16'd0, c}, 32'h0);
    check("norm_rst_done", {31'd0, done}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("norm_rst_no_done", {31'd0, done}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0; a = 16'h4200; b = 16'h3C00; start = 1'b1;
    collect("post_rst", 16'h4000, 3);

    check("no_double_done", dbl, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
